// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memory port.
// mem_ready is the memory's ready for the request held on MemRead/MemWrite with
// the address selected by IorD. The request and address stay stable until the
// cycle mem_ready = 1, and that cycle completes the access.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       mem_ready;
    logic       PCWrite;
    logic       Branch;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic [3:0] state;
    logic       instr_done;
    logic       trap;

    modport master (
        input  opcode, func, mem_ready,
        output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
               state, instr_done, trap
    );

    modport slave (
        output opcode, func, mem_ready,
        input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
               state, instr_done, trap
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: Moore FSM stepping fetch/decode/execute/
// memory/writeback, stalling on mem_ready and trapping on unsupported encodings.
module mc_control_fsm (
    input  logic             clk,
    input  logic             rst_n,
    mc_control_fsm_if.master bus
);
    localparam logic [3:0] S_RST    = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_IMMEX  = 4'd11;
    localparam logic [3:0] S_IMMWB  = 4'd12;
    localparam logic [3:0] S_TRAP   = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    logic [3:0] r_state;
    logic       r_trap;
    logic [3:0] w_next;
    logic       w_func_ok;

    logic       w_pc_write, w_branch, w_iord, w_mem_read, w_mem_write, w_ir_write;
    logic       w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a, w_instr_done;
    logic [1:0] w_alu_src_b, w_alu_op, w_pc_src;

    always_comb begin
        case (bus.func)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b101010: w_func_ok = 1'b1;
            default:                         w_func_ok = 1'b0;
        endcase
    end

    // The trap flag latches on the edge that enters TRAP and only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RST;
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP) r_trap <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:    w_next = S_FETCH;
            S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                                  w_next = w_func_ok ? S_EXEC : S_TRAP;
                    OP_LW, OP_SW:                              w_next = S_MEMADR;
                    OP_BEQ:                                    w_next = S_BRANCH;
                    OP_J:                                      w_next = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: w_next = S_IMMEX;
                    default:                                   w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode == OP_LW)      w_next = S_MEMRD;
                else if (bus.opcode == OP_SW) w_next = S_MEMWR;
                else                          w_next = S_TRAP;
            end
            S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IMMWB: w_next = S_FETCH;
            S_EXEC:   w_next = S_ALUWB;
            S_IMMEX:  w_next = S_IMMWB;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_TRAP;
        endcase
    end

    always_comb begin
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_pc_src     = 2'b00;
        w_instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
            end
            // Branch target is precomputed into ALUOut while the opcode is decoded.
            S_DECODE: w_alu_src_b = 2'b11;
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
            end
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_iord       = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = bus.mem_ready;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            S_ALUWB: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 2'b01;
                w_branch     = 1'b1;
                w_pc_src     = 2'b01;
                w_instr_done = 1'b1;
            end
            S_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_src     = 2'b10;
                w_instr_done = 1'b1;
            end
            S_IMMEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = 2'b11;
            end
            S_IMMWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite    = w_pc_write;
    assign bus.Branch     = w_branch;
    assign bus.IorD       = w_iord;
    assign bus.MemRead    = w_mem_read;
    assign bus.MemWrite   = w_mem_write;
    assign bus.IRWrite    = w_ir_write;
    assign bus.RegDst     = w_reg_dst;
    assign bus.MemtoReg   = w_mem_to_reg;
    assign bus.RegWrite   = w_reg_write;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ALUOp      = w_alu_op;
    assign bus.PCSrc      = w_pc_src;
    assign bus.state      = r_state;
    assign bus.instr_done = w_instr_done;
    assign bus.trap       = r_trap;
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control sequencer for the MIPS core. It replaces the single-cycle decoder when the datapath is rebuilt around a shared memory port, instruction register (IR) and ALUOut register. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the per-cycle datapath enables. It stalls on a memory ready handshake and traps on unsupported encodings.

## Interface
Parameters: none. The state encoding is fixed; see Operation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- func  in  6  IR[5:0]
- mem_ready  in  1  memory has completed the current read or write this cycle
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load, qualified by ALU zero in the datapath
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- RegDst  out  1  register destination: 1 = rd, 0 = rt
- MemtoReg  out  1  register write data: 1 = MDR, 0 = ALUOut
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs
- ALUSrcB  out  2  ALU B input: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  out  2  00 = add, 01 = sub, 10 = by func, 11 = immediate op (by opcode)
- PCSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state, for debug
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- trap  out  1  sticky flag: illegal instruction detected

## Operation
State encodings: RST = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6, EXEC = 7, ALUWB = 8, BRANCH = 9, JUMP = 10, IMMEX = 11, IMMWB = 12, TRAP = 15. Codes 13 and 14 are unused and go to TRAP on the next edge.

Outputs are Moore, decoded from state. The only exception is the handshake gating described in FETCH and MEMWR. Any output not listed for a state is 0.

Per-state outputs and transitions:
- RST: all outputs 0. Next state FETCH.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSrc = 00.
  - IRWrite and PCWrite equal mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when it is 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. This precomputes the branch target into ALUOut. Next state by opcode:
  - 000000 with a supported func (100000, 100010, 100100, 100101, 100110, 100111, 101010) → EXEC. Any other func → TRAP.
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - 001000, 001100, 001101, 001110, 001010 (addi, andi, ori, xori, slti) → IMMEX.
  - Any other opcode → TRAP.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state MEMRD for lw, MEMWR for sw. The opcode is re-read here; IR is unchanged.
- MEMRD: IorD = 1, MemRead = 1. Stay while mem_ready = 0; go to MEMWB when it is 1.
- MEMWB: RegDst = 0, MemtoReg = 1, RegWrite = 1, instr_done = 1. Next state FETCH.
- MEMWR: IorD = 1, MemWrite = 1. Stay while mem_ready = 0. When mem_ready = 1, instr_done = 1 and next state is FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next state ALUWB.
- ALUWB: RegDst = 1, MemtoReg = 0, RegWrite = 1, instr_done = 1. Next state FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, Branch = 1, PCSrc = 01, instr_done = 1. Next state FETCH.
- JUMP: PCWrite = 1, PCSrc = 10, instr_done = 1. Next state FETCH.
- IMMEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 11. Next state IMMWB.
- IMMWB: RegDst = 0, MemtoReg = 0, RegWrite = 1, instr_done = 1. Next state FETCH.
- TRAP: all datapath outputs 0, trap = 1. Stays in TRAP until reset. The trap flag is registered, set on entry to TRAP, and cleared only by reset.

## Timing
- Reset: rst_n low forces state = RST and trap = 0 asynchronously. All outputs go to 0 in the same cycle. The first FETCH is one cycle after rst_n is released.
- Reset asserted mid-instruction aborts it immediately. No further writes occur.
- Cycle counts, with mem_ready = 1 on the first cycle of each access:
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - immediate ops: 4
- Each mem_ready = 0 cycle adds one cycle to FETCH, MEMRD or MEMWR.
- MemRead and MemWrite are held constant for the whole wait. Address select stays stable until mem_ready is seen.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- instr_done is high for exactly one cycle per retired instruction. It never pulses for a trapped instruction.
- opcode and func are sampled only in DECODE and MEMADR.

## Test plan
- Reset, then run add (opcode 0, func 100000) with mem_ready = 1 → state sequence 0,1,2,7,8,1. RegWrite = 1 and RegDst = 1 only in ALUWB. instr_done pulses in cycle 4.
- lw with 2 wait cycles in FETCH and 1 in MEMRD → FETCH lasts 3 cycles with IRWrite/PCWrite high only in the third. Total 8 cycles. MemtoReg = 1 and RegWrite = 1 in MEMWB.
- sw with mem_ready low for 3 cycles → MEMWR held 4 cycles with MemWrite = 1 and IorD = 1 throughout. RegWrite is never 1.
- beq and j back-to-back → BRANCH has Branch = 1, ALUOp = 01, PCSrc = 01. JUMP has PCWrite = 1, PCSrc = 10. 3 cycles each.
- Opcode 111111, then R-type with func 000000 after reset → each enters TRAP from DECODE. trap = 1 held, instr_done never pulses, all enables 0 for 10 cycles.
- rst_n dropped during MEMRD of lw → state = 0 and outputs 0 in the same cycle. After release, FETCH follows and no RegWrite occurs.
